// File: rtl/aes_stream_pkg.sv
// Shared constants and drain FSM state for the AES byte/word stream blocks.
// Used by the receive packer and the output unpacker.
package aes_stream_pkg;

   localparam int BLOCK_BYTES     = 16;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int BYTE_CNT_W      = $clog2(BLOCK_BYTES);

   typedef enum logic {
      D_IDLE,
      D_SEND
   } drain_state_t;

   // LSB of byte lane k within a word; lane 0 is the MSB byte.
   function automatic logic [4:0] lane_lsb(input logic [1:0] k);
      return 5'd24 - {k, 3'b000};
   endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Inter-byte idle counter: cleared on demand, counts while running,
// saturates, and flags expiry on its last count.
module rx_idle_timer #(
   parameter int TIMEOUT_CLKS = 35000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT_CLKS);

   logic [W-1:0] cnt;

   assign expire = run && (cnt == W'(TIMEOUT_CLKS - 1));

   // Idle count since the last accepted byte, saturating.
   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (run && cnt != '1)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/rx_block_packer.sv
// Packs received bytes into 128-bit blocks held in two ping-pong banks
// and drains each full bank to the core as four 32-bit words.
module rx_block_packer
   import aes_stream_pkg::*;
#(
   parameter int TIMEOUT_CLKS = 35000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_dv_in,
   input  logic [7:0]  rx_byte_in,
   input  logic        word_ready_in,
   output logic [31:0] word_out,
   output logic        word_valid_out,
   output logic        block_last_out,
   output logic        timeout_err_out,
   output logic        overrun_err_out,
   output logic        busy_out
);

   logic [31:0] bank [2][WORDS_PER_BLOCK];
   logic [1:0]  full;
   logic        fill_bank;
   logic        drain_bank;
   logic [BYTE_CNT_W-1:0] byte_cnt;
   logic [1:0]  word_cnt;
   logic        valid_q;
   drain_state_t state;

   logic xfer;
   logic free_now;
   logic target_free;
   logic accept;
   logic drop;
   logic fill_done;
   logic expire;
   logic to_fire;
   logic self_ready;
   logic other_ready;

   assign xfer     = valid_q && word_ready_in;
   assign free_now = xfer && (word_cnt == 2'd3);

   // A bank being freed on this edge may take a new byte.
   assign target_free = !full[fill_bank]
                     || (free_now && drain_bank == fill_bank);

   assign accept    = rx_dv_in && target_free;
   assign drop      = rx_dv_in && !target_free;
   assign fill_done = accept
                   && byte_cnt == BYTE_CNT_W'(BLOCK_BYTES - 1);

   // An accepted byte on the expiry cycle cancels the discard.
   assign to_fire = expire && !accept;

   assign self_ready  = full[drain_bank]
                     || (fill_done && fill_bank == drain_bank);
   assign other_ready = full[~drain_bank]
                     || (fill_done && fill_bank != drain_bank);

   rx_idle_timer #(
      .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (accept || to_fire),
      .run   (byte_cnt != '0),
      .expire(expire)
   );

   // Bank RAM write; first byte of a word lands in its MSBs.
   always_ff @(posedge clk) begin
      if (accept)
         bank[fill_bank][byte_cnt[3:2]]
             [lane_lsb(byte_cnt[1:0]) +: 8] <= rx_byte_in;
   end

   // Fill side: byte position, bank select and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt        <= '0;
         fill_bank       <= 1'b0;
         overrun_err_out <= 1'b0;
         timeout_err_out <= 1'b0;
      end else begin
         overrun_err_out <= drop;
         timeout_err_out <= to_fire;
         if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (fill_done)
               fill_bank <= ~fill_bank;
         end else if (to_fire) begin
            byte_cnt <= '0;
         end
      end
   end

   // Bank full flags: set by fill completion, cleared by last word.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 2'b00;
      end else begin
         if (free_now)
            full[drain_bank] <= 1'b0;
         if (fill_done)
            full[fill_bank] <= 1'b1;
      end
   end

   // Drain FSM: presents words of the drain bank until word 3 moves.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= D_IDLE;
         valid_q    <= 1'b0;
         word_cnt   <= 2'd0;
         drain_bank <= 1'b0;
      end else begin
         unique case (state)
            D_IDLE: begin
               if (self_ready) begin
                  state    <= D_SEND;
                  valid_q  <= 1'b1;
                  word_cnt <= 2'd0;
               end
            end
            D_SEND: begin
               if (xfer) begin
                  word_cnt <= word_cnt + 2'd1;
                  if (word_cnt == 2'd3) begin
                     drain_bank <= ~drain_bank;
                     if (!other_ready) begin
                        state   <= D_IDLE;
                        valid_q <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state   <= D_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign word_valid_out = valid_q;
   assign word_out       = valid_q ? bank[drain_bank][word_cnt] : '0;
   assign block_last_out = valid_q && (word_cnt == 2'd3);
   assign busy_out       = (byte_cnt != '0) || (|full);

endmodule

// File: tb/tb_rx_block_packer.sv
// Self-checking bench for rx_block_packer: table of blocks plus
// hand-written overrun, timeout and reset sequences, scoreboarded.
module tb_rx_block_packer;

   localparam int TO = 50;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_dv_in;
   logic [7:0]  rx_byte_in;
   logic        word_ready_in;
   logic [31:0] word_out;
   logic        word_valid_out;
   logic        block_last_out;
   logic        timeout_err_out;
   logic        overrun_err_out;
   logic        busy_out;

   rx_block_packer #(
      .TIMEOUT_CLKS(TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_dv_in       (rx_dv_in),
      .rx_byte_in     (rx_byte_in),
      .word_ready_in  (word_ready_in),
      .word_out       (word_out),
      .word_valid_out (word_valid_out),
      .block_last_out (block_last_out),
      .timeout_err_out(timeout_err_out),
      .overrun_err_out(overrun_err_out),
      .busy_out       (busy_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] w;
      logic        last;
   } exp_t;

   typedef struct {
      logic [7:0]  first;
      int          stall;
      logic [31:0] w0;
   } vec_t;

   exp_t sb[$];
   vec_t vt[4];
   int errors  = 0;
   int checks  = 0;
   int tmo_cnt = 0;
   int ovr_cnt = 0;

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Scoreboard pop on every transfer; error pulses tallied.
   always @(negedge clk) begin
      exp_t e;
      if (timeout_err_out) tmo_cnt++;
      if (overrun_err_out) ovr_cnt++;
      if (!rst && word_valid_out && word_ready_in) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got %h want none", word_out);
         end else begin
            e = sb.pop_front();
            check("word", {32'd0, word_out}, {32'd0, e.w});
            check("last", {63'd0, block_last_out}, {63'd0, e.last});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_dv_in   = 1'b1;
      rx_byte_in = b;
      @(posedge clk);
      #1;
      rx_dv_in = 1'b0;
   endtask

   task automatic push_block(input logic [7:0] f);
      for (int w = 0; w < 4; w++) begin
         logic [31:0] x;
         for (int j = 0; j < 4; j++)
            x[31-8*j -: 8] = f + 8'(4 * w + j);
         sb.push_back('{x, (w == 3)});
      end
   endtask

   task automatic send_block(input logic [7:0] f);
      push_block(f);
      for (int k = 0; k < 16; k++)
         send_byte(f + 8'(k));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain_count(output int n, output int first);
      n = 0;
      first = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (word_valid_out && word_ready_in) begin
            if (n == 0) first = i;
            n++;
         end else if (n > 0) begin
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic outs_zero(input string nm);
      check(nm, {27'd0, word_out, word_valid_out, block_last_out,
                 timeout_err_out, overrun_err_out, busy_out}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, f, t, o;
      vt[0] = '{8'h00, 0,  32'h00010203};
      vt[1] = '{8'h00, 10, 32'h00010203};
      vt[2] = '{8'hF0, 3,  32'hF0F1F2F3};
      vt[3] = '{8'hFE, 0,  32'hFEFF0001};

      rst = 1'b1;
      rx_dv_in = 1'b0;
      rx_byte_in = 8'h00;
      word_ready_in = 1'b0;
      idle(3);
      @(negedge clk);
      outs_zero("reset_outs");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Table: single blocks, with and without stall.
      for (int v = 0; v < 4; v++) begin
         word_ready_in = (vt[v].stall == 0);
         send_block(vt[v].first);
         @(negedge clk);
         check("lat_valid", {63'd0, word_valid_out}, 64'd1);
         check("w0", {32'd0, word_out}, {32'd0, vt[v].w0});
         if (vt[v].stall > 0) begin
            for (int s = 1; s < vt[v].stall; s++) begin
               @(negedge clk);
               check("held", {31'd0, word_valid_out, block_last_out,
                              word_out}, {31'd0, 1'b1, 1'b0, vt[v].w0});
            end
            @(posedge clk);
            #1;
            word_ready_in = 1'b1;
         end
         drain_count(n, f);
         check("drain_n", 64'(n), (vt[v].stall == 0) ? 64'd3 : 64'd4);
         check("drain_first", 64'(f), 64'd1);
      end

      // Two blocks back-to-back, no bubble.
      word_ready_in = 1'b0;
      send_block(8'h20);
      send_block(8'h40);
      word_ready_in = 1'b1;
      drain_count(n, f);
      check("b2b_n", 64'(n), 64'd8);

      // Overrun on the 33rd byte.
      word_ready_in = 1'b0;
      o = ovr_cnt;
      send_block(8'h60);
      send_block(8'h80);
      send_byte(8'hEE);
      @(negedge clk);
      check("ovr_pulse", {63'd0, overrun_err_out}, 64'd1);
      @(posedge clk);
      #1;
      word_ready_in = 1'b1;
      drain_count(n, f);
      check("ovr_drain_n", 64'(n), 64'd8);
      check("ovr_count", 64'(ovr_cnt - o), 64'd1);

      // Timeout discards a partial block.
      t = tmo_cnt;
      for (int k = 0; k < 5; k++)
         send_byte(8'h11 + 8'(k));
      idle(TO);
      @(negedge clk);
      check("tmo_pulse", {63'd0, timeout_err_out}, 64'd1);
      @(posedge clk);
      #1;
      check("tmo_busy", {63'd0, busy_out}, 64'd0);
      check("tmo_count", 64'(tmo_cnt - t), 64'd1);
      send_block(8'h00);
      drain_count(n, f);
      check("tmo_clean_n", 64'(n), 64'd4);
      check("tmo_clean_first", 64'(f), 64'd1);

      // Byte exactly on the expiry cycle wins.
      t = tmo_cnt;
      push_block(8'h30);
      for (int k = 0; k < 5; k++)
         send_byte(8'h30 + 8'(k));
      idle(TO - 1);
      for (int k = 5; k < 16; k++)
         send_byte(8'h30 + 8'(k));
      drain_count(n, f);
      check("exp_edge_n", 64'(n), 64'd4);
      check("exp_edge_tmo", 64'(tmo_cnt - t), 64'd0);

      // Reset mid-fill.
      t = tmo_cnt;
      o = ovr_cnt;
      for (int k = 0; k < 8; k++)
         send_byte(8'(k));
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      outs_zero("rst_fill_outs");
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_block(8'h00);
      drain_count(n, f);
      check("rst_fill_n", 64'(n), 64'd4);

      // Reset mid-drain, during word 2.
      word_ready_in = 1'b0;
      send_block(8'h50);
      @(negedge clk);
      check("md_valid", {63'd0, word_valid_out}, 64'd1);
      @(posedge clk);
      #1;
      word_ready_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("md_word2", {32'd0, word_out}, 64'h58595A5B);
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      outs_zero("rst_drain_outs");
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      send_block(8'h00);
      drain_count(n, f);
      check("rst_drain_n", 64'(n), 64'd4);
      check("rst_no_err", 64'((tmo_cnt - t) + (ovr_cnt - o)), 64'd0);
      check("sb_left", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
